// File: rtl/tsp_display_ctrl.sv
// tsp_display_ctrl
// Front-panel driver for a TSP solver.
//   Mode 00: live tour cost.
//   Mode 10: best tour cost seen so far.
//   Mode 01: scrolls through the tour, showing two adjacent cities per step.
//   Mode 11: freezes the display.
// Optional feature macro: TSP_DISP_BCD_EN
//   Defined:   modes 00/10 show the cost in decimal, using a sequential
//              shift-add-3 converter.
//   Undefined: modes 00/10 show the cost in hex.
module tsp_display_ctrl #(
  parameter int N_CITY       = 64,
  parameter int IDX_W        = 6,
  parameter int PERF_W       = 19,
  parameter int N_DIGIT      = 6,
  parameter int REFRESH_LOG2 = 17,
  parameter int SCROLL_LOG2  = 23
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           sw,
  input  logic [PERF_W-1:0]    performance,
  input  logic                 perf_valid,
  output logic [IDX_W-1:0]     path_addr,
  input  logic [IDX_W-1:0]     path_data,
  output logic [4*N_DIGIT-1:0] digits,
  output logic [9:0]           ledr
);

  localparam int CNT_W = SCROLL_LOG2 + IDX_W + 1;
  localparam logic [4*N_DIGIT-1:0] ALL_F = {N_DIGIT{4'hF}};
  localparam logic [1:0] MODE_PATH = 2'b01;
  localparam logic [1:0] MODE_BEST = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD_A,
    ST_RD_B,
    ST_LATCH
  } fetch_state_t;

  // Advance a city index, wrapping at the real city count rather than at 2**IDX_W.
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] x);
    return (x == IDX_W'(N_CITY - 1)) ? '0 : x + IDX_W'(1);
  endfunction

  logic [CNT_W-1:0]     r_cnt;
  logic [PERF_W-1:0]    r_best;
  logic [IDX_W-1:0]     r_idx;
  logic [IDX_W-1:0]     r_path_addr;
  logic [IDX_W-1:0]     r_city_a;
  fetch_state_t         r_state;
  logic [4*N_DIGIT-1:0] r_digits;
  logic [9:0]           r_ledr;

  logic                 w_refresh_tick;
  logic                 w_scroll_tick;
  logic [IDX_W-1:0]     w_idx_next;
  logic                 w_value_mode;
  logic [PERF_W-1:0]    w_value;
  logic                 w_value_blank;
  logic                 w_latch_upd;
  logic [9:0]           w_idx_led;
  logic [4*N_DIGIT-1:0] w_path_digits;

  assign w_refresh_tick = (r_cnt[REFRESH_LOG2-1:0] == '0);
  assign w_scroll_tick  = (r_cnt[SCROLL_LOG2-1:0] == '0);
  assign w_idx_next     = wrap_inc(r_idx);
  // Modes 00 and 10 both display a cost value; sw[1] selects best over live.
  assign w_value_mode   = ~sw[0];
  assign w_value        = (sw == MODE_BEST) ? r_best : performance;
  // An all-ones best means no sample has arrived yet, so show a blank display.
  assign w_value_blank  = (sw == MODE_BEST) && (r_best == '1);
  // City B is taken straight from the memory bus in the same cycle it arrives.
  assign w_latch_upd    = (r_state == ST_LATCH) && (sw == MODE_PATH);
  assign w_idx_led      = 10'(r_idx);

  assign path_addr = r_path_addr;
  assign digits    = r_digits;
  assign ledr      = r_ledr;

  // Free-running timebase; both ticks are decoded from its low bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_cnt <= '0;
    else      r_cnt <= r_cnt + CNT_W'(1);
  end

  // Track the lowest cost seen. Only a strictly lower sample replaces it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_best <= '1;
    end else if (perf_valid && (performance < r_best)) begin
      r_best <= performance;
    end
  end

  // Path fetch FSM: advance idx, read city idx, then read city idx+1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_path_addr <= '0;
      r_city_a    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_path_addr <= '0;
          if ((sw == MODE_PATH) && w_scroll_tick) begin
            r_idx       <= w_idx_next;
            r_path_addr <= w_idx_next;
            r_state     <= ST_RD_A;
          end
        end
        ST_RD_A: begin
          r_path_addr <= wrap_inc(r_idx);
          r_state     <= ST_RD_B;
        end
        ST_RD_B: begin
          r_city_a    <= path_data;
          r_path_addr <= '0;
          r_state     <= ST_LATCH;
        end
        default: begin
          r_path_addr <= '0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  // Layout of a path step: city A in digits 1:0, city B in digits 4:3.
  always_comb begin
    w_path_digits        = ALL_F;
    w_path_digits[7:0]   = 8'(r_city_a);
    w_path_digits[11:8]  = 4'h0;
    w_path_digits[19:12] = 8'(path_data);
    w_path_digits[23:20] = 4'h0;
  end

`ifdef TSP_DISP_BCD_EN
  localparam int CONV_W = $clog2(PERF_W + 1);

  logic                 r_conv_busy;
  logic [CONV_W-1:0]    r_conv_cnt;
  logic [PERF_W-1:0]    r_conv_bin;
  logic [4*N_DIGIT-1:0] r_conv_bcd;
  logic                 r_conv_ovf;
  logic [4*N_DIGIT-1:0] w_bcd_adj;

  // Add-3 correction for every BCD digit before each left shift.
  genvar gi;
  generate
    for (gi = 0; gi < N_DIGIT; gi++) begin : g_add3
      assign w_bcd_adj[4*gi+3:4*gi] = (r_conv_bcd[4*gi+3:4*gi] >= 4'd5) ?
                                      r_conv_bcd[4*gi+3:4*gi] + 4'd3 :
                                      r_conv_bcd[4*gi+3:4*gi];
    end
  endgenerate
`else
  logic [4*N_DIGIT-1:0] w_hex_digits;

  // Hex layout: five value nibbles, a zero sixth digit, blanks above that.
  always_comb begin
    w_hex_digits        = ALL_F;
    w_hex_digits[19:0]  = 20'(w_value);
    w_hex_digits[23:20] = 4'h0;
  end
`endif

  // Display and LED registers. The mode switches always drive ledr[9:8],
  // except in path mode, where a latched step owns the whole LED bus.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_digits <= ALL_F;
      r_ledr   <= '0;
`ifdef TSP_DISP_BCD_EN
      r_conv_busy <= 1'b0;
      r_conv_cnt  <= '0;
      r_conv_bin  <= '0;
      r_conv_bcd  <= '0;
      r_conv_ovf  <= 1'b0;
`endif
    end else begin
      if (sw != MODE_PATH) r_ledr[9:8] <= sw;
      if (w_latch_upd) begin
        r_digits <= w_path_digits;
        r_ledr   <= w_idx_led;
      end
`ifdef TSP_DISP_BCD_EN
      // Refresh ticks that arrive during a conversion are dropped. A 1 shifted
      // out of the top digit means the value does not fit in N_DIGIT digits.
      if (r_conv_busy) begin
        if (r_conv_cnt == '0) begin
          r_conv_busy <= 1'b0;
          if (w_value_mode) r_digits <= r_conv_ovf ? ALL_F : r_conv_bcd;
        end else begin
          r_conv_cnt <= r_conv_cnt - CONV_W'(1);
          r_conv_bin <= r_conv_bin << 1;
          r_conv_bcd <= {w_bcd_adj[4*N_DIGIT-2:0], r_conv_bin[PERF_W-1]};
          r_conv_ovf <= r_conv_ovf | w_bcd_adj[4*N_DIGIT-1];
        end
      end else if (w_value_mode && w_refresh_tick) begin
        if (w_value_blank) begin
          r_digits <= ALL_F;
        end else begin
          r_conv_busy <= 1'b1;
          r_conv_cnt  <= CONV_W'(PERF_W);
          r_conv_bin  <= w_value;
          r_conv_bcd  <= '0;
          r_conv_ovf  <= 1'b0;
        end
      end
`else
      if (w_value_mode && w_refresh_tick) begin
        r_digits <= w_value_blank ? ALL_F : w_hex_digits;
      end
`endif
    end
  end

endmodule
